// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode encodings, control word tables and FSM states for the sequencer
package ctrl_pkg;

  localparam int PCNT_W = 8;

  typedef enum logic {
    S_DECODE = 1'b0,
    S_EXEC   = 1'b1
  } state_t;

  localparam logic [6:0] OP_ALU    = 7'b0010001;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0011001;
  localparam logic [6:0] OP_MOV    = 7'b0011000;
  localparam logic [6:0] OP_NOP    = 7'b1100001;
  localparam logic [6:0] OP_STORE  = 7'b1101000;
  localparam logic [6:0] OP_BRANCH = 7'b1100010;

  localparam logic [22:0] WA_ALU    = 23'b01110100000101001100011;
  localparam logic [22:0] WA_LOAD   = 23'b01110101000100001100011;
  localparam logic [22:0] WA_ALUI   = 23'b01100100000101011100011;
  localparam logic [22:0] WA_MOV    = 23'b01111100000101011100011;
  localparam logic [22:0] WA_NOP    = 23'b00000000000000000000000;
  localparam logic [22:0] WA_STORE  = 23'b01100100000000000100000;
  localparam logic [22:0] WA_BRANCH = 23'b01100100000000011100010;

  localparam logic [22:0] WB_STORE  = 23'b00000000000000000100000;
  localparam logic [22:0] WB_BRANCH = 23'b00000000000000000000010;

  localparam logic [PCNT_W-1:0] PH_SINGLE = 8'd1;
  localparam logic [PCNT_W-1:0] PH_DOUBLE = 8'd2;

  // Table phase counts may exceed what a given instance can sequence.
  function automatic logic [PCNT_W-1:0] clip_phases(input logic [PCNT_W-1:0] p,
                                                     input int unsigned max_p);
    if (p > PCNT_W'(max_p)) return PCNT_W'(max_p);
    return p;
  endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// rtl/ctrl_decode_rom.sv - combinational opcode lookup: legality, phase count, both control words
module ctrl_decode_rom
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 7,
  parameter int SIG_W      = 23,
  parameter int MAX_PHASES = 2
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal,
  output logic [PCNT_W-1:0]   phases,
  output logic [SIG_W-1:0]    word_a,
  output logic [SIG_W-1:0]    word_b
);

  logic [PCNT_W-1:0] raw_phases;

  always_comb begin
    legal      = 1'b1;
    raw_phases = PH_SINGLE;
    word_a     = '0;
    word_b     = '0;
    case (opcode)
      OPCODE_W'(OP_ALU):    word_a = SIG_W'(WA_ALU);
      OPCODE_W'(OP_LOAD):   word_a = SIG_W'(WA_LOAD);
      OPCODE_W'(OP_ALUI):   word_a = SIG_W'(WA_ALUI);
      OPCODE_W'(OP_MOV):    word_a = SIG_W'(WA_MOV);
      OPCODE_W'(OP_NOP):    word_a = SIG_W'(WA_NOP);
      OPCODE_W'(OP_STORE): begin
        word_a     = SIG_W'(WA_STORE);
        word_b     = SIG_W'(WB_STORE);
        raw_phases = PH_DOUBLE;
      end
      OPCODE_W'(OP_BRANCH): begin
        word_a     = SIG_W'(WA_BRANCH);
        word_b     = SIG_W'(WB_BRANCH);
        raw_phases = PH_DOUBLE;
      end
      default: legal = 1'b0;
    endcase
  end

  assign phases = clip_phases(raw_phases, MAX_PHASES);

endmodule

// File: rtl/ctrl_seq_unit.sv
// rtl/ctrl_seq_unit.sv - sequenced opcode-to-control-word decoder with stall, flush and idle policy
module ctrl_seq_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 7,
  parameter int SIG_W        = 23,
  parameter int MAX_PHASES   = 2,
  parameter bit HOLD_ON_IDLE = 1'b0,
  localparam int PH_W        = (MAX_PHASES > 1) ? $clog2(MAX_PHASES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic                stall,
  input  logic                flush,
  output logic [SIG_W-1:0]    signals,
  output logic                sig_valid,
  output logic                illegal,
  output logic [PH_W-1:0]     phase
);

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [PH_W-1:0]     cnt;

  logic [OPCODE_W-1:0] rom_op;
  logic                rom_legal;
  logic [PCNT_W-1:0]   rom_phases;
  logic [SIG_W-1:0]    rom_word_a;
  logic [SIG_W-1:0]    rom_word_b;
  logic [PH_W-1:0]     last_ph;
  logic                accept;

  // One ROM serves both states: no accept can happen while sequencing.
  assign rom_op   = (state == S_EXEC) ? op_q : opcode;
  assign last_ph  = PH_W'(rom_phases - 8'd1);
  assign op_ready = (state == S_DECODE) && !stall && !flush && reset;
  assign accept   = op_valid && op_ready;

  ctrl_decode_rom #(
    .OPCODE_W  (OPCODE_W),
    .SIG_W     (SIG_W),
    .MAX_PHASES(MAX_PHASES)
  ) u_rom (
    .opcode(rom_op),
    .legal (rom_legal),
    .phases(rom_phases),
    .word_a(rom_word_a),
    .word_b(rom_word_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_DECODE;
      op_q      <= '0;
      cnt       <= '0;
      signals   <= '0;
      sig_valid <= 1'b0;
      illegal   <= 1'b0;
      phase     <= '0;
    end else if (flush) begin
      state     <= S_DECODE;
      cnt       <= '0;
      signals   <= '0;
      sig_valid <= 1'b0;
      illegal   <= 1'b0;
      phase     <= '0;
    end else if (!stall) begin
      if (state == S_DECODE) begin
        phase <= '0;
        if (accept && rom_legal) begin
          signals   <= rom_word_a;
          sig_valid <= 1'b1;
          illegal   <= 1'b0;
          op_q      <= opcode;
          if (rom_phases > 8'd1) begin
            state <= S_EXEC;
            cnt   <= PH_W'(1);
          end
        end else if (accept) begin
          signals   <= '0;
          sig_valid <= 1'b0;
          illegal   <= 1'b1;
        end else begin
          sig_valid <= 1'b0;
          illegal   <= 1'b0;
          if (!HOLD_ON_IDLE) signals <= '0;
        end
      end else begin
        signals   <= rom_word_b;
        sig_valid <= 1'b1;
        illegal   <= 1'b0;
        phase     <= cnt;
        if (cnt == last_ph) begin
          state <= S_DECODE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
- Parametrised, sequenced successor to the single-cycle opcode-to-control-word decoder. Sits between instruction fetch and the datapath.
- Accepts an opcode over a valid/ready handshake and emits a registered control word one cycle later.
- Multi-phase opcodes are stepped through a phase counter.
- Adds stall, flush, illegal-opcode detection and a selectable idle policy.

Parameters:
- OPCODE_W, 7, opcode width.
- SIG_W, 23, control word width.
- MAX_PHASES, 2, maximum cycles per opcode; the phase counter is clog2(MAX_PHASES) bits wide.
- HOLD_ON_IDLE, 0. When 1, the last word is held while no opcode is accepted (legacy behaviour). When 0, the block drives a zero bubble.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- opcode, input, OPCODE_W: instruction opcode.
- op_valid, input, 1: opcode is presented.
- op_ready, output, 1: block can accept an opcode this cycle.
- stall, input, 1: freezes all state and outputs.
- flush, input, 1: kills any in-flight sequence.
- signals, output, SIG_W: registered control word.
- sig_valid, output, 1: signals carries a real (non-bubble) word this cycle.
- illegal, output, 1: one-cycle pulse, aligned with signals, for an unknown opcode.
- phase, output, clog2(MAX_PHASES): current phase index of the word on signals.

Behaviour:
- Reset (reset=0, asynchronous): signals=0, sig_valid=0, illegal=0, phase=0, state=S_DECODE. op_ready is combinational, so it is low while reset=0.
- op_ready = (state==S_DECODE) && !stall && !flush && reset.
- Accept occurs when op_valid && op_ready at a rising edge.
- Latency: the word appears on signals on the edge that accepts the opcode (registered, one cycle after presentation).
- Priority at each edge: flush > stall > normal operation.
- Flush: signals=0, sig_valid=0, illegal=0, phase=0, state=S_DECODE. An opcode presented in the same cycle is not accepted.
- Stall (flush=0): every register holds, including state and phase.
- S_DECODE, on accept of a legal opcode:
  - signals=WORD_A(opcode), sig_valid=1, illegal=0, phase=0.
  - If PHASES(opcode)>1, go to S_EXEC with the counter at 1; otherwise stay in S_DECODE.
- S_DECODE, on accept of an unknown opcode: signals=0, sig_valid=0, illegal=1, phase=0; stay in S_DECODE.
- S_DECODE, no accept: sig_valid=0, illegal=0. signals=0 if HOLD_ON_IDLE=0, else signals holds its value.
- S_EXEC, each non-stalled, non-flushed cycle:
  - signals=WORD_B(latched opcode), sig_valid=1, phase=counter.
  - When counter==PHASES-1, return to S_DECODE; otherwise increment the counter.
  - The opcode is latched at accept, so later opcode changes are ignored.
- PHASES values above MAX_PHASES are clipped to MAX_PHASES.
- Back-to-back single-phase opcodes sustain one accept per cycle.
- Reset asserted mid-S_EXEC aborts immediately to reset values; no residual phase is emitted after release.
- Opcode table (WORD_A / PHASES / WORD_B):
  - 0010001: 01110100000101001100011 / 1
  - 0000011: 01110101000100001100011 / 1
  - 0011001: 01100100000101011100011 / 1
  - 0011000: 01111100000101011100011 / 1
  - 1100001: 00000000000000000000000 / 1 (NOP; sig_valid=1)
  - 1101000: 01100100000000000100000 / 2 / 00000000000000000100000
  - 1100010: 01100100000000011100010 / 2 / 00000000000000000000010
  - All other opcodes are illegal.

Decomposition:
- Shared package ctrl_pkg:
  - opcode localparams.
  - WORD_A and WORD_B constants.
  - per-opcode phase counts.
  - state encoding S_DECODE/S_EXEC.
- One combinational sub-module, ctrl_decode_rom: opcode -> {legal, phases, word_a, word_b}.
- ctrl_seq_unit owns the handshake, FSM, phase counter, opcode latch and output registers.

Test Plan:
1. Reset low, then high; opcode=0010001, op_valid=1 for one cycle -> next edge: signals=01110100000101001100011, sig_valid=1, phase=0. Following idle cycle: signals=0, sig_valid=0 (HOLD_ON_IDLE=0).
2. Opcode=1101000 accepted -> cycle 1: WORD_A, phase=0, op_ready=0. Cycle 2: signals=00000000000000000100000, phase=1. Cycle 3: op_ready=1.
3. Opcode=1111111 accepted -> illegal=1 for exactly one cycle, signals=0, sig_valid=0, state stays S_DECODE.
4. Opcode=1100010 accepted, stall=1 for 3 cycles during S_EXEC -> signals and phase frozen. After release: WORD_B=00000000000000000000010 emitted once, then op_ready=1.
5. Flush and stall both high during S_EXEC with op_valid=1 -> flush wins: signals=0, sig_valid=0, S_DECODE, opcode not accepted.
6. HOLD_ON_IDLE=1: accept 0011000, then idle 4 cycles -> signals stays 01111100000101011100011 with sig_valid=0. Assert reset mid-S_EXEC -> all outputs 0 immediately.
